pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/pc_target.sv | 50 +++++
 rtl/pc_gen.sv | 162 ++++++++++++++++
 tb/tb_pc_gen.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator: FSM states,
// RISC-V branch funct3 encodings and the default boot address.
package pc_gen_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_target.sv
// Execute-stage control-flow decode: branch condition, redirect target and
// target alignment flag. Purely combinational.
module pc_target
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic            i_is_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_cmp_eq,
  input  logic            i_cmp_lt,
  input  logic            i_cmp_ltu,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign
);

  logic w_taken;

  // NOTE: every signal driven here gets a value before the case/if, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  w_taken = i_cmp_eq;
      F3_BNE:  w_taken = !i_cmp_eq;
      F3_BLT:  w_taken = i_cmp_lt;
      F3_BGE:  w_taken = !i_cmp_lt;
      F3_BLTU: w_taken = i_cmp_ltu;
      F3_BGEU: w_taken = !i_cmp_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_target = i_ex_pc + i_imm;
    if (i_is_jalr) begin
      o_target = (i_rs1_data + i_imm) & ~XLEN'(1);
    end
  end

  assign o_redirect = i_is_jalr || i_is_jal || (i_is_b && w_taken);
  assign o_misalign = (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: single-outstanding fetch FSM, one-entry instruction
// buffer and trap/mret/execute redirect handling with response kill.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_link,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_b,
  input  logic [2:0]      b_funct3,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_ltu,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_kill, w_kill_next;
  logic            r_inst_valid;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc, r_inst_link;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_addr;

  logic            w_tgt_redirect, w_tgt_misalign;
  logic [XLEN-1:0] w_tgt;
  logic            w_ex_redirect, w_ex_misalign, w_redirect;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_req_valid, w_resp_take;

  pc_target #(.XLEN(XLEN)) u_target (
    .i_ex_pc    (ex_pc),
    .i_imm      (imm),
    .i_rs1_data (rs1_data),
    .i_is_jal   (is_jal),
    .i_is_jalr  (is_jalr),
    .i_is_b     (is_b),
    .i_funct3   (b_funct3),
    .i_cmp_eq   (cmp_eq),
    .i_cmp_lt   (cmp_lt),
    .i_cmp_ltu  (cmp_ltu),
    .o_redirect (w_tgt_redirect),
    .o_target   (w_tgt),
    .o_misalign (w_tgt_misalign)
  );

  // Misalignment is only reported when the execute redirect would have won.
  assign w_ex_redirect = ex_valid && w_tgt_redirect;
  assign w_ex_misalign = w_ex_redirect && w_tgt_misalign && !trap_valid && !mret_valid;
  assign w_redirect    = trap_valid || mret_valid || (w_ex_redirect && !w_tgt_misalign);
  assign w_redirect_pc = trap_valid ? mtvec : (mret_valid ? mepc : w_tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_kill_next  = r_kill;
    w_req_valid  = 1'b0;
    w_resp_take  = 1'b0;
    case (r_state)
      ST_BOOT: w_state_next = ST_REQ;
      ST_REQ: begin
        w_req_valid = !(r_inst_valid && !inst_ready);
        if (w_req_valid && req_ready) begin
          w_state_next = ST_WAIT;
          w_kill_next  = w_redirect;
        end
      end
      ST_WAIT: begin
        if (resp_valid) begin
          w_state_next = ST_REQ;
          w_kill_next  = 1'b0;
          w_resp_take  = !r_kill && !w_redirect;
        end else if (w_redirect) begin
          w_kill_next = 1'b1;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc            <= RESET_VEC;
      r_kill          <= 1'b0;
      r_inst_valid    <= 1'b0;
      r_inst          <= '0;
      r_inst_pc       <= '0;
      r_inst_link     <= '0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_kill     <= w_kill_next;
      r_misalign <= w_ex_misalign;
      if (w_ex_misalign) begin
        r_misalign_addr <= w_tgt;
      end

      if (w_redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_resp_take) begin
        r_pc <= r_pc + XLEN'(4);
      end

      if (w_redirect) begin
        r_inst_valid <= 1'b0;
      end else if (w_resp_take) begin
        r_inst_valid <= 1'b1;
      end else if (inst_ready) begin
        r_inst_valid <= 1'b0;
      end

      if (w_resp_take) begin
        r_inst      <= resp_inst;
        r_inst_pc   <= r_pc;
        r_inst_link <= r_pc + XLEN'(4);
      end
    end
  end

  assign req_valid     = w_req_valid;
  assign req_addr      = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_link     = r_inst_link;
  assign misalign      = r_misalign;
  assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: memory responder, fetch/instruction
// scoreboards and one task per scenario.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_inst = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst, inst_pc, inst_link;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        is_jal = 1'b0, is_jalr = 1'b0, is_b = 1'b0;
  logic [2:0]  b_funct3 = '0;
  logic        cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic [31:0] imm = '0, rs1_data = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] mtvec = '0;
  logic        mret_valid = 1'b0;
  logic [31:0] mepc = '0;
  logic        misalign;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q_req[$];
  logic [31:0] q_inst[$];
  int resp_delay = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_link(inst_link),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .is_jal(is_jal), .is_jalr(is_jalr), .is_b(is_b),
    .b_funct3(b_funct3), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .imm(imm), .rs1_data(rs1_data),
    .trap_valid(trap_valid), .mtvec(mtvec), .mret_valid(mret_valid), .mepc(mepc),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory: answers each accepted request resp_delay cycles after the
  // earliest legal response slot.
  initial begin : responder
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          resp_valid = 1'b1;
          resp_inst  = mem_word(pend_addr);
          pend       = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      #1;
      if (req_valid && req_ready) begin
        pend      = 1'b1;
        pend_cnt  = resp_delay;
        pend_addr = req_addr;
      end
    end
  end

  // Scoreboard side: pops expectations as fetches and deliveries happen.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst == 1'b0) begin
        if (req_valid && req_ready) begin
          n_checks++;
          if (q_req.size() == 0) begin
            n_errors++;
            $display("FAIL fetch_addr: unexpected request at %h, none expected", req_addr);
          end else begin
            e = q_req.pop_front();
            if (req_addr !== e) begin
              n_errors++;
              $display("FAIL fetch_addr: got %h expected %h", req_addr, e);
            end
          end
        end
        if (inst_valid && inst_ready) begin
          n_checks++;
          if (q_inst.size() == 0) begin
            n_errors++;
            $display("FAIL inst_deliver: unexpected inst at pc %h", inst_pc);
          end else begin
            e = q_inst.pop_front();
            if (inst_pc !== e || inst !== mem_word(e) || inst_link !== e + 32'd4) begin
              n_errors++;
              $display("FAIL inst_deliver: got pc %h inst %h link %h expected pc %h inst %h link %h",
                       inst_pc, inst, inst_link, e, mem_word(e), e + 32'd4);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_redirects();
    ex_valid = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; is_b = 1'b0;
    trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  // Called at a negedge; holds the execute inputs for exactly one cycle.
  task automatic ex_pulse(input logic jal, input logic jalr, input logic b, input logic [2:0] f3,
                          input logic eq, input logic lt, input logic ltu,
                          input logic [31:0] pc, input logic [31:0] im, input logic [31:0] rs1);
    ex_valid = 1'b1; is_jal = jal; is_jalr = jalr; is_b = b; b_funct3 = f3;
    cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu; ex_pc = pc; imm = im; rs1_data = rs1;
    @(negedge clk);
    clear_redirects();
  endtask

  // Called at a negedge; lets exactly n requests through, then closes req_ready.
  task automatic issue_fetches(input int n);
    int cnt = 0;
    int cyc = 0;
    req_ready = 1'b1;
    while (cnt < n && cyc < 60) begin
      #1;
      if (req_valid && req_ready) cnt++;
      @(negedge clk);
      clear_redirects();
      cyc++;
    end
    req_ready = 1'b0;
    n_checks++;
    if (cnt != n) begin
      n_errors++;
      $display("FAIL fetch_count: got %0d requests expected %0d", cnt, n);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (q_req.size() == 0 && q_inst.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({req_valid, inst_valid, misalign} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000", {req_valid, inst_valid, misalign});
    end
    n_checks++;
    if (req_addr !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL reset_pc: got %h expected 80000000", req_addr);
    end
    n_checks++;
    if ({inst, inst_pc, inst_link, misalign_addr} !== 128'd0) begin
      n_errors++;
      $display("FAIL reset_regs: got %h %h %h %h expected all zero", inst, inst_pc, inst_link, misalign_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_cycle: req_valid %b expected 0", req_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (req_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL boot_to_req: req_valid %b expected 1", req_valid);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      q_req.push_back(32'h8000_0000 + 32'(4 * i));
      q_inst.push_back(32'h8000_0000 + 32'(4 * i));
    end
    @(negedge clk);
    issue_fetches(3);
    wait_drain(ok);
    n_checks++;
    if (!ok || req_addr !== 32'h8000_000C) begin
      n_errors++;
      $display("FAIL sequential: drained %b pc %h expected 1 8000000c", ok, req_addr);
    end
  endtask

  // One branch: expect req_addr == exp afterwards and, if fetch, fetch it.
  task automatic branch_case(input string name, input logic [2:0] f3, input logic eq,
                             input logic lt, input logic ltu, input logic [31:0] pc,
                             input logic [31:0] im, input logic [31:0] exp, input bit fetch);
    bit ok;
    @(negedge clk);
    ex_pulse(1'b0, 1'b0, 1'b1, f3, eq, lt, ltu, pc, im, 32'h0);
    #1;
    n_checks++;
    if (req_addr !== exp || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: req_addr %h inst_valid %b expected %h 0", name, req_addr, inst_valid, exp);
    end
    if (fetch) begin
      q_req.push_back(exp);
      q_inst.push_back(exp);
      @(negedge clk);
      issue_fetches(1);
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL %s_fetch: drained 0 expected 1", name);
      end
    end
  endtask

  task automatic test_branch();
    branch_case("bne_taken",   3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'hFFFF_FFF8, 32'h8000_0008, 1'b1);
    branch_case("beq_not",     3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'hFFFF_FFF8, 32'h8000_000C, 1'b1);
    branch_case("bge_not",     3'b101, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0040, 32'h8000_0010, 1'b0);
    branch_case("bltu_taken",  3'b110, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_0010, 32'h8000_0020, 1'b1);
  endtask

  task automatic test_jalr();
    bit ok;
    @(negedge clk);
    ex_pulse(1'b0, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0024, 32'd4, 32'h8000_0103);
    #1;
    n_checks++;
    if (misalign !== 1'b1 || misalign_addr !== 32'h8000_0106 || req_addr !== 32'h8000_0024) begin
      n_errors++;
      $display("FAIL jalr_misalign: misalign %b addr %h pc %h expected 1 80000106 80000024",
               misalign, misalign_addr, req_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (misalign !== 1'b0) begin
      n_errors++;
      $display("FAIL misalign_pulse: misalign %b expected 0", misalign);
    end
    @(negedge clk);
    ex_pulse(1'b0, 1'b1, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0024, 32'd4, 32'h8000_0101);
    #1;
    n_checks++;
    if (req_addr !== 32'h8000_0104 || misalign !== 1'b0) begin
      n_errors++;
      $display("FAIL jalr_target: pc %h misalign %b expected 80000104 0", req_addr, misalign);
    end
    q_req.push_back(32'h8000_0104);
    q_inst.push_back(32'h8000_0104);
    @(negedge clk);
    issue_fetches(1);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL jalr_fetch: drained 0 expected 1");
    end
  endtask

  task automatic test_wait_redirect();
    bit ok;
    bit seen;
    resp_delay = 3;
    q_req.push_back(32'h8000_0108);
    @(negedge clk);
    issue_fetches(1);
    ex_pulse(1'b1, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0200, 32'h40, 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (inst_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL wait_kill: inst_valid seen 1 expected 0");
    end
    n_checks++;
    if (req_addr !== 32'h8000_0240 || req_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_redirect: pc %h req_valid %b expected 80000240 1", req_addr, req_valid);
    end
    resp_delay = 0;
    q_req.push_back(32'h8000_0240);
    q_inst.push_back(32'h8000_0240);
    @(negedge clk);
    issue_fetches(1);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL wait_redirect_fetch: drained 0 expected 1");
    end
  endtask

  task automatic test_trap_priority();
    bit ok;
    @(negedge clk);
    trap_valid = 1'b1;
    mtvec = 32'h8000_0100;
    ex_pulse(1'b1, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 32'd8, 32'h0);
    #1;
    n_checks++;
    if (req_addr !== 32'h8000_0100) begin
      n_errors++;
      $display("FAIL trap_over_jal: pc %h expected 80000100", req_addr);
    end
    @(negedge clk);
    mret_valid = 1'b1;
    mepc = 32'h8000_0080;
    ex_pulse(1'b1, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 32'd8, 32'h0);
    #1;
    n_checks++;
    if (req_addr !== 32'h8000_0080) begin
      n_errors++;
      $display("FAIL mret_over_jal: pc %h expected 80000080", req_addr);
    end
    q_req.push_back(32'h8000_0080);
    q_inst.push_back(32'h8000_0080);
    @(negedge clk);
    issue_fetches(1);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL mret_fetch: drained 0 expected 1");
    end
  endtask

  task automatic test_handshake_redirect();
    bit ok;
    q_req.push_back(32'h8000_0084);
    q_req.push_back(32'h8000_0400);
    q_inst.push_back(32'h8000_0400);
    @(negedge clk);
    ex_valid = 1'b1; is_jal = 1'b1; ex_pc = 32'h8000_0500; imm = 32'hFFFF_FF00;
    issue_fetches(2);
    wait_drain(ok);
    n_checks++;
    if (!ok || req_addr !== 32'h8000_0404) begin
      n_errors++;
      $display("FAIL handshake_kill: drained %b pc %h expected 1 80000404", ok, req_addr);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit leaked;
    q_req.push_back(32'h8000_0404);
    q_inst.push_back(32'h8000_0404);
    @(negedge clk);
    inst_ready = 1'b0;
    issue_fetches(1);
    req_ready = 1'b1;
    leaked = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (req_valid) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin
      n_errors++;
      $display("FAIL full_stall: req_valid seen 1 expected 0");
    end
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0404) begin
      n_errors++;
      $display("FAIL buffer_hold: valid %b pc %h expected 1 80000404", inst_valid, inst_pc);
    end
    q_req.push_back(32'h8000_0408);
    q_inst.push_back(32'h8000_0408);
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0408) begin
      n_errors++;
      $display("FAIL resume: req_valid %b pc %h expected 1 80000408", req_valid, req_addr);
    end
    @(negedge clk);
    req_ready = 1'b0;
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL resume_fetch: drained 0 expected 1");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    resp_delay = 1;
    q_req.push_back(32'h8000_040C);
    @(negedge clk);
    issue_fetches(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_addr !== 32'h8000_0000 || req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: pc %h req_valid %b expected 80000000 0", req_addr, req_valid);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (inst_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL boot_resp_ignored: inst_valid seen 1 expected 0");
    end
    resp_delay = 0;
    q_req.push_back(32'h8000_0000);
    q_inst.push_back(32'h8000_0000);
    @(negedge clk);
    issue_fetches(1);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL post_reset_fetch: drained 0 expected 1");
    end
  endtask

  initial begin : main
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_wait_redirect();
    test_trap_priority();
    test_handshake_redirect();
    test_back_pressure();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
